// File: rtl/muldiv_pkg.sv
//------------------------------------------------------------------------------
// Module   : muldiv_pkg
// Brief    : Shared types and constants for the HI/LO multiply/divide sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package muldiv_pkg;

   // Sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Operation select encoding on div_or_mult
   localparam logic OP_MULT = 1'b1;
   localparam logic OP_DIV  = 1'b0;

   // Default operand width and the matching iteration counter width
   localparam int WIDTH_DEFAULT = 32;
   localparam int CNT_W         = $clog2(WIDTH_DEFAULT + 1);

   // Iteration counter width for an arbitrary operand width
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
//------------------------------------------------------------------------------
// Module   : muldiv_step
// Brief    : One combinational iteration of the iterative arithmetic engine.
//            Mult: add-or-skip of the multiplicand magnitude into the upper
//            half, then shift the 2*WIDTH accumulator right by one.
//            Div : restoring trial subtract of the divisor from the shifted
//            remainder; the quotient bit shifts into the low half.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             op,
   input  logic [WIDTH-1:0] acc_hi,
   input  logic [WIDTH-1:0] acc_lo,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] nxt_hi,
   output logic [WIDTH-1:0] nxt_lo
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;
   logic           fits;

   // Compute the next accumulator halves for the selected operation
   always_comb begin
      sum     = {1'b0, acc_hi} + {1'b0, operand};
      shifted = {acc_hi, acc_lo[WIDTH-1]};
      fits    = (shifted >= {1'b0, operand});
      trial   = shifted - {1'b0, operand};
      nxt_hi  = acc_hi;
      nxt_lo  = acc_lo;
      if (op == OP_MULT) begin
         // The carry out of the add becomes the new MSB after the shift
         if (acc_lo[0]) begin
            {nxt_hi, nxt_lo} = {sum, acc_lo[WIDTH-1:1]};
         end else begin
            {nxt_hi, nxt_lo} = {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
         end
      end else begin
         // Remainder stays below the divisor, so WIDTH bits always suffice
         if (fits) begin
            nxt_hi = trial[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
         end else begin
            nxt_hi = shifted[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/muldiv_seq.sv
//------------------------------------------------------------------------------
// Module   : muldiv_seq
// Brief    : Sequencer for the shared HI/LO resource. Runs a signed iterative
//            shift-add multiply or restoring divide over WIDTH cycles on operand
//            magnitudes, applies the sign fix-up, then drives HI/LO data and
//            write enables with a one-cycle done pulse.
//            Build option MULDIV_DIVZERO_EN: a divide by zero skips the
//            iterations, pulses done with div_zero and writes nothing.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             div_or_mult,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             hi_write,
   output logic             lo_write,
   output logic             div_zero
);

   localparam int CW = cnt_width(WIDTH);

   state_t             state;
   state_t             state_nxt;
   logic               op;
   logic               sign_a;
   logic               sign_b;
   logic [WIDTH-1:0]   operand;
   logic [WIDTH-1:0]   acc_hi;
   logic [WIDTH-1:0]   acc_lo;
   logic [CW-1:0]      cnt;

   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   step_hi;
   logic [WIDTH-1:0]   step_lo;
   logic [2*WIDTH-1:0] product;
   logic [2*WIDTH-1:0] product_neg;
   logic               skip;
   logic               dz;

   assign a_mag       = a[WIDTH-1] ? -a : a;
   assign b_mag       = b[WIDTH-1] ? -b : b;
   assign product     = {acc_hi, acc_lo};
   assign product_neg = -product;

`ifdef MULDIV_DIVZERO_EN
   assign skip     = (div_or_mult == OP_DIV) && (b == '0);

   // Remember whether the accepted request was a short-circuited divide by zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dz <= 1'b0;
      end else if ((state == IDLE) && start) begin
         dz <= skip;
      end
   end

   assign div_zero = (state == DONE) && dz;
`else
   assign skip     = 1'b0;
   assign dz       = 1'b0;
   assign div_zero = 1'b0;
`endif

   muldiv_step #(
      .WIDTH   (WIDTH)
   ) u_step (
      .op      (op),
      .acc_hi  (acc_hi),
      .acc_lo  (acc_lo),
      .operand (operand),
      .nxt_hi  (step_hi),
      .nxt_lo  (step_lo)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and state-derived status outputs
   always_comb begin
      state_nxt = state;
      busy      = (state != IDLE);
      done      = 1'b0;
      hi_write  = 1'b0;
      lo_write  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = skip ? DONE : RUN;
            end
         end
         RUN: begin
            if (cnt == CW'(WIDTH - 1)) begin
               state_nxt = FIX;
            end
         end
         FIX: begin
            state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            hi_write  = !dz;
            lo_write  = !dz;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Operand capture, iteration accumulators and sign fix-up into HI/LO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op      <= OP_DIV;
         sign_a  <= 1'b0;
         sign_b  <= 1'b0;
         operand <= '0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         cnt     <= '0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op     <= div_or_mult;
                  sign_a <= a[WIDTH-1];
                  sign_b <= b[WIDTH-1];
                  cnt    <= '0;
                  acc_hi <= '0;
                  if (div_or_mult == OP_MULT) begin
                     acc_lo  <= b_mag;
                     operand <= a_mag;
                  end else begin
                     acc_lo  <= a_mag;
                     operand <= b_mag;
                  end
               end
            end
            RUN: begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               cnt    <= cnt + CW'(1);
            end
            FIX: begin
               if (op == OP_MULT) begin
                  {hi, lo} <= (sign_a ^ sign_b) ? product_neg : product;
               end else begin
                  lo <= (sign_a ^ sign_b) ? -acc_lo : acc_lo;
                  hi <= sign_a ? -acc_hi : acc_hi;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_muldiv_seq
// Brief    : Directed self-checking bench for muldiv_seq (WIDTH = 32).
//            Expectations for the divide-by-zero case follow MULDIV_DIVZERO_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_muldiv_seq;

   logic        clk         = 1'b0;
   logic        rst_n       = 1'b0;
   logic        start       = 1'b0;
   logic        div_or_mult = 1'b0;
   logic [31:0] a           = '0;
   logic [31:0] b           = '0;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        hi_write;
   logic        lo_write;
   logic        div_zero;

   int total    = 0;
   int passed   = 0;
   int failed   = 0;
   int wr_cnt   = 0;
   int done_cnt = 0;

   muldiv_seq #(
      .WIDTH       (32)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .div_or_mult (div_or_mult),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo),
      .hi_write    (hi_write),
      .lo_write    (lo_write),
      .div_zero    (div_zero)
   );

   always #5 clk = ~clk;

   // Count write-enable and done cycles seen at active edges
   always @(posedge clk) begin
      if (hi_write) wr_cnt <= wr_cnt + 1;
      if (done)     done_cnt <= done_cnt + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Launch one request, optionally inject stray starts, then check the result
   task automatic run_op(input string tag, input logic op, input logic [31:0] av,
                         input logic [31:0] bv, input bit inject, input int exp_lat,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input logic exp_dz, input int exp_wr);
      int lat;
      int wr0;
      int dn0;
      @(negedge clk);
      div_or_mult = op;
      a           = av;
      b           = bv;
      start       = 1'b1;
      wr0         = wr_cnt;
      dn0         = done_cnt;
      @(posedge clk);
      @(negedge clk);
      start       = 1'b0;
      a           = $urandom;
      b           = $urandom;
      div_or_mult = 1'($urandom);
      lat         = 1;
      chk({tag, ".busy_rise"}, 64'(busy), 64'd1);
      while (!done && lat < 100) begin
         if (inject && (lat == 3 || lat == 20)) begin
            start       = 1'b1;
            div_or_mult = ~op;
            a           = $urandom;
            b           = $urandom;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      chk({tag, ".latency"},  64'(lat),      64'(exp_lat));
      chk({tag, ".hi"},       64'(hi),       64'(exp_hi));
      chk({tag, ".lo"},       64'(lo),       64'(exp_lo));
      chk({tag, ".hi_write"}, 64'(hi_write), 64'(exp_wr));
      chk({tag, ".lo_write"}, 64'(lo_write), 64'(exp_wr));
      chk({tag, ".div_zero"}, 64'(div_zero), 64'(exp_dz));
      @(negedge clk);
      chk({tag, ".done_fall"}, 64'(done),           64'd0);
      chk({tag, ".busy_fall"}, 64'(busy),           64'd0);
      chk({tag, ".writes"},    64'(wr_cnt - wr0),   64'(exp_wr));
      chk({tag, ".dones"},     64'(done_cnt - dn0), 64'd1);
   endtask

   initial begin
      int wr0;
      int dn0;

      // Reset state
      #12;
      chk("rst.busy",     64'(busy),     64'd0);
      chk("rst.done",     64'(done),     64'd0);
      chk("rst.hi",       64'(hi),       64'd0);
      chk("rst.lo",       64'(lo),       64'd0);
      chk("rst.hi_write", 64'(hi_write), 64'd0);
      chk("rst.lo_write", 64'(lo_write), 64'd0);
      chk("rst.div_zero", 64'(div_zero), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 7 * -3 = -21
      run_op("mul_7_m3",   1'b1, 32'd7,          32'hFFFF_FFFD, 1'b0, 34, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1);
      // (-2^31) * (-2^31) = 2^62
      run_op("mul_min",    1'b1, 32'h8000_0000,  32'h8000_0000, 1'b0, 34, 32'h4000_0000, 32'h0000_0000, 1'b0, 1);
      // 100 / 7 = 14 r 2
      run_op("div_100_7",  1'b0, 32'd100,        32'd7,         1'b0, 34, 32'd2,         32'd14,        1'b0, 1);
      // -7 / 2 = -3 r -1
      run_op("div_m7_2",   1'b0, 32'hFFFF_FFF9,  32'd2,         1'b0, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1);
      // -7 / -2 = 3 r -1
      run_op("div_m7_m2",  1'b0, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 1'b0, 34, 32'hFFFF_FFFF, 32'd3,         1'b0, 1);
      // 7 / -2 = -3 r 1
      run_op("div_7_m2",   1'b0, 32'd7,          32'hFFFF_FFFE, 1'b0, 34, 32'd1,         32'hFFFF_FFFD, 1'b0, 1);
      // -2^31 / -1 wraps to -2^31 r 0
      run_op("div_min_m1", 1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 1'b0, 34, 32'h0000_0000, 32'h8000_0000, 1'b0, 1);
`ifdef MULDIV_DIVZERO_EN
      // Short-circuit: no writes, previous HI/LO remain visible
      run_op("div_5_0",    1'b0, 32'd5,          32'd0,         1'b0, 1,  32'h0000_0000, 32'h8000_0000, 1'b1, 0);
`else
      run_op("div_5_0",    1'b0, 32'd5,          32'd0,         1'b0, 34, 32'd5,         32'hFFFF_FFFF, 1'b0, 1);
`endif
      // -5 * 65537 = -327685 with stray starts during RUN
      run_op("mul_inject", 1'b1, 32'hFFFF_FFFB,  32'h0001_0001, 1'b1, 34, 32'hFFFF_FFFF, 32'hFFFA_FFFB, 1'b0, 1);

      // Asynchronous reset in the middle of RUN discards the operation
      @(negedge clk);
      div_or_mult = 1'b1;
      a           = 32'd1000;
      b           = 32'd1000;
      start       = 1'b1;
      wr0         = wr_cnt;
      dn0         = done_cnt;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("midrst.busy_before", 64'(busy), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst.busy",     64'(busy),     64'd0);
      chk("midrst.done",     64'(done),     64'd0);
      chk("midrst.hi",       64'(hi),       64'd0);
      chk("midrst.lo",       64'(lo),       64'd0);
      chk("midrst.hi_write", 64'(hi_write), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("midrst.writes", 64'(wr_cnt - wr0),   64'd0);
      chk("midrst.dones",  64'(done_cnt - dn0), 64'd0);
      chk("midrst.idle",   64'(busy),           64'd0);

      // Normal operation after reset release
      run_op("mul_3_4",    1'b1, 32'd3,          32'd4,         1'b0, 34, 32'd0,         32'd12,        1'b0, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
